// File: rtl/heap_bank_sched.sv
`timescale 1ns/1ps
// heap_bank_sched: ping-pong frame scheduler in front of the heapsort engine.
// Captures fs-paced samples into one of two RAM banks. Each full frame of
// N = 2^(LEVEL+1)-1 samples is handed to the sort engine while the other bank
// fills. If both banks are occupied, samples are dropped and overrun is flagged.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   fs         in   sample-rate square wave, rising edge = new sample
//   en_rec_in  in   record enable, sample edges ignored while low
//   data_in    in   sample, valid at the fs rising edge
//   sort_done  in   one-cycle pulse, sort engine finished its bank
//   wr_en      out  RAM write strobe, one cycle per sample
//   wr_bank    out  bank being written
//   wr_addr    out  write address inside the bank
//   wr_data    out  captured sample
//   sort_start out  one-cycle pulse, sort sort_bank
//   sort_bank  out  bank owned by the sort engine
//   busy       out  sort engine owns a bank
//   overrun    out  sticky, at least one sample dropped
//   frame_cnt  out  frames handed to the sorter, wraps
module heap_bank_sched #(
  parameter int unsigned LEVEL  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = LEVEL + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  input  logic              en_rec_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sort_done,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              sort_start,
  output logic              sort_bank,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned       N         = (2 ** (LEVEL + 1)) - 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic {LD_FILL = 1'b0, LD_HOLD = 1'b1} ld_state_t;
  typedef enum logic {SO_IDLE = 1'b0, SO_BUSY = 1'b1} so_state_t;

  // State and output registers
  ld_state_t         r_ld_state;
  so_state_t         r_so_state;
  logic              r_fs_d;
  logic              r_fill_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_pending;
  logic              r_wr_en;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_sort_start;
  logic              r_sort_bank;
  logic              r_overrun;
  logic [15:0]       r_frame_cnt;

  // Next-state values
  ld_state_t         w_ld_state_nxt;
  so_state_t         w_so_state_nxt;
  logic              w_fill_bank_nxt;
  logic [ADDR_W-1:0] w_wr_cnt_nxt;
  logic              w_pending_nxt;
  logic              w_wr_en_nxt;
  logic              w_wr_bank_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [DATA_W-1:0] w_wr_data_nxt;
  logic              w_sort_start_nxt;
  logic              w_sort_bank_nxt;
  logic              w_overrun_nxt;
  logic [15:0]       w_frame_cnt_nxt;

  logic              w_ev;
  logic              w_frame_done;
  logic              w_sorter_free;
  logic              w_handover;

  // Accepted sample edge (rst gates it so a reset cycle never records)
  assign w_ev = fs & ~r_fs_d & en_rec_in & ~rst;

  // Last address of a frame is on the write port this cycle
  assign w_frame_done = (r_ld_state == LD_FILL) & r_wr_en & (r_wr_addr == LAST_ADDR);

  // A finishing sorter can accept the next bank in the very same cycle
  assign w_sorter_free = (r_so_state == SO_IDLE) | sort_done;

  // Bank handed to the sorter next cycle: fresh frame, or the held one
  assign w_handover = (w_frame_done & w_sorter_free) |
                      ((r_ld_state == LD_HOLD) & r_pending & sort_done);

  // Next-state and output logic for loader and sorter tracking
  always_comb begin
    w_ld_state_nxt   = r_ld_state;
    w_so_state_nxt   = r_so_state;
    w_fill_bank_nxt  = r_fill_bank;
    w_wr_cnt_nxt     = r_wr_cnt;
    w_pending_nxt    = r_pending;
    w_wr_en_nxt      = 1'b0;
    w_wr_bank_nxt    = r_wr_bank;
    w_wr_addr_nxt    = r_wr_addr;
    w_wr_data_nxt    = r_wr_data;
    w_sort_start_nxt = 1'b0;
    w_sort_bank_nxt  = r_sort_bank;
    w_overrun_nxt    = r_overrun;
    w_frame_cnt_nxt  = r_frame_cnt;

    case (r_ld_state)
      LD_FILL: begin
        if (w_ev) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_bank_nxt = r_fill_bank;
          w_wr_addr_nxt = r_wr_cnt;
          w_wr_data_nxt = data_in;
          w_wr_cnt_nxt  = (r_wr_cnt == LAST_ADDR) ? '0 : r_wr_cnt + ADDR_W'(1);
        end
        if (w_frame_done && !w_sorter_free) begin
          // Both banks full: park the completed bank until the sorter frees up
          w_pending_nxt  = 1'b1;
          w_ld_state_nxt = LD_HOLD;
        end
      end
      LD_HOLD: begin
        if (w_ev) begin
          w_overrun_nxt = 1'b1;
        end
        if (r_pending && sort_done) begin
          w_pending_nxt  = 1'b0;
          w_ld_state_nxt = LD_FILL;
        end
      end
      default: begin
        w_ld_state_nxt = LD_FILL;
      end
    endcase

    // Handover: the bank just filled goes to the sorter, filling swaps banks
    if (w_handover) begin
      w_sort_start_nxt = 1'b1;
      w_sort_bank_nxt  = r_fill_bank;
      w_fill_bank_nxt  = ~r_fill_bank;
      w_frame_cnt_nxt  = r_frame_cnt + 16'd1;
    end

    case (r_so_state)
      SO_IDLE: begin
        if (w_handover) begin
          w_so_state_nxt = SO_BUSY;
        end
      end
      SO_BUSY: begin
        if (sort_done && !w_handover) begin
          w_so_state_nxt = SO_IDLE;
        end
      end
      default: begin
        w_so_state_nxt = SO_IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_state   <= LD_FILL;
      r_so_state   <= SO_IDLE;
      r_fs_d       <= 1'b1;
      r_fill_bank  <= 1'b0;
      r_wr_cnt     <= '0;
      r_pending    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_bank    <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_sort_start <= 1'b0;
      r_sort_bank  <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_ld_state   <= w_ld_state_nxt;
      r_so_state   <= w_so_state_nxt;
      r_fs_d       <= fs;
      r_fill_bank  <= w_fill_bank_nxt;
      r_wr_cnt     <= w_wr_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_wr_data    <= w_wr_data_nxt;
      r_sort_start <= w_sort_start_nxt;
      r_sort_bank  <= w_sort_bank_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_cnt  <= w_frame_cnt_nxt;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_bank    = r_wr_bank;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign sort_start = r_sort_start;
  assign sort_bank  = r_sort_bank;
  assign busy       = (r_so_state == SO_BUSY);
  assign overrun    = r_overrun;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_heap_bank_sched.sv
`timescale 1ns/1ps
// tb_heap_bank_sched: directed scenarios plus randomized traffic, checked every
// cycle against a frame/ownership model of the ping-pong scheduler.
module tb_heap_bank_sched;

  localparam int unsigned LEVEL  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = LEVEL + 1;
  localparam int          N      = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              fs;
  logic              en_rec_in;
  logic [DATA_W-1:0] data_in;
  logic              sort_done;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sort_start;
  logic              sort_bank;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_cnt;

  always #5 clk = ~clk;

  heap_bank_sched #(.LEVEL(LEVEL), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .fs(fs), .en_rec_in(en_rec_in), .data_in(data_in),
    .sort_done(sort_done), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .sort_start(sort_start), .sort_bank(sort_bank),
    .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fill bank, frame position, completed frame waiting, sorter ownership
  bit          m_fs_prev   = 1'b1;
  int          m_fill      = 0;
  int          m_cnt       = 0;
  bit          m_owned     = 1'b0;
  int          m_sort_bank = 0;
  bit          m_ready     = 1'b0;
  int          m_ready_bank = 0;
  bit          m_overrun   = 1'b0;
  int          m_frame_cnt = 0;
  bit          e_wr_en     = 1'b0;
  int          e_wr_bank   = 0;
  int          e_wr_addr   = 0;
  logic [31:0] e_wr_data   = '0;
  bit          e_start     = 1'b0;

  // Monitor record for the directed literal checks
  int          n_wr = 0;
  int          n_start = 0;
  int          last_wr_bank = 0;
  int          last_wr_addr = 0;
  logic [31:0] last_wr_data = '0;
  int          last_start_bank = 0;

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    bit ev;
    bit holding;
    bit nxt_wr;
    bit nxt_start;
    if (chk_on) begin
      // Compare current outputs against the model's prediction for this cycle
      chk("wr_en", 64'(wr_en), 64'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_bank", 64'(wr_bank), 64'(e_wr_bank));
        chk("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
        chk("wr_data", 64'(wr_data), 64'(e_wr_data));
      end
      chk("sort_start", 64'(sort_start), 64'(e_start));
      if (m_owned || e_start) chk("sort_bank", 64'(sort_bank), 64'(m_sort_bank));
      chk("busy", 64'(busy), 64'(m_owned));
      chk("overrun", 64'(overrun), 64'(m_overrun));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frame_cnt));
      if (wr_en && busy) chk("bank_conflict", 64'(wr_bank != sort_bank), 64'd1);

      if (wr_en) begin
        n_wr++; last_wr_bank = int'(wr_bank); last_wr_addr = int'(wr_addr); last_wr_data = wr_data;
      end
      if (sort_start) begin
        n_start++; last_start_bank = int'(sort_bank);
      end

      // Advance the model with this cycle's inputs
      nxt_wr = 1'b0;
      nxt_start = 1'b0;
      if (rst) begin
        m_fs_prev = 1'b1; m_fill = 0; m_cnt = 0; m_owned = 1'b0; m_sort_bank = 0;
        m_ready = 1'b0; m_overrun = 1'b0; m_frame_cnt = 0;
      end else begin
        ev = fs && !m_fs_prev && en_rec_in;
        holding = m_ready;
        if (e_wr_en && e_wr_addr == N - 1) begin
          m_ready = 1'b1;
          m_ready_bank = e_wr_bank;
        end
        if (m_ready && (!m_owned || sort_done)) begin
          nxt_start = 1'b1;
          m_sort_bank = m_ready_bank;
          m_owned = 1'b1;
          m_frame_cnt = (m_frame_cnt + 1) % 65536;
          m_fill = 1 - m_fill;
          m_ready = 1'b0;
        end else if (sort_done) begin
          m_owned = 1'b0;
        end
        if (ev) begin
          if (holding) begin
            m_overrun = 1'b1;
          end else begin
            nxt_wr = 1'b1;
            e_wr_bank = m_fill;
            e_wr_addr = m_cnt;
            e_wr_data = data_in;
            m_cnt = (m_cnt + 1) % N;
          end
        end
        m_fs_prev = fs;
      end
      e_wr_en = nxt_wr;
      e_start = nxt_start;
    end
  end

  // One sample edge: fs high for two cycles, low for two, returns in the 4th
  task automatic sample(input logic [31:0] d);
    @(posedge clk); #1; fs = 1'b1; data_in = d;
    @(posedge clk); #1;
    @(posedge clk); #1; fs = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    int n0;
    int ph;
    rst = 1'b1; fs = 1'b1; en_rec_in = 1'b1; data_in = '0; sort_done = 1'b0;
    @(posedge clk); #1; chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // Reset release with fs already high is not an edge
    repeat (5) @(posedge clk);
    #1;
    chk("lit_rst_nwr", 64'(n_wr), 64'd0);
    chk("lit_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("lit_rst_overrun", 64'(overrun), 64'd0);
    chk("lit_rst_busy", 64'(busy), 64'd0);
    fs = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // First frame into bank 0, handed over with the sorter idle
    for (int d = 1; d <= 7; d++) sample(32'(d));
    chk("lit_f1_nstart", 64'(n_start), 64'd1);
    chk("lit_f1_sort_bank", 64'(last_start_bank), 64'd0);
    chk("lit_f1_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("lit_f1_busy", 64'(busy), 64'd1);
    chk("lit_f1_last_addr", 64'(last_wr_addr), 64'd6);
    chk("lit_f1_last_data", 64'(last_wr_data), 64'd7);
    sample(32'd8);
    chk("lit_f2_bank", 64'(last_wr_bank), 64'd1);
    chk("lit_f2_addr", 64'(last_wr_addr), 64'd0);

    // Second frame completes while the sorter is busy: hold and drop
    for (int d = 9; d <= 14; d++) sample(32'(d));
    sample(32'd15);
    chk("lit_hold_nwr", 64'(n_wr), 64'd14);
    chk("lit_hold_last_data", 64'(last_wr_data), 64'd14);
    chk("lit_hold_overrun", 64'(overrun), 64'd1);
    chk("lit_hold_nstart", 64'(n_start), 64'd1);

    // Sorter finishes: held bank 1 starts the next cycle
    @(posedge clk); #1; sort_done = 1'b1;
    @(posedge clk); #1; sort_done = 1'b0;
    chk("lit_rel_start", 64'(sort_start), 64'd1);
    chk("lit_rel_bank", 64'(sort_bank), 64'd1);
    chk("lit_rel_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("lit_rel_overrun", 64'(overrun), 64'd1);
    sample(32'd16);
    chk("lit_rel_wr_bank", 64'(last_wr_bank), 64'd0);
    chk("lit_rel_wr_addr", 64'(last_wr_addr), 64'd0);

    // Reset, then sort_done coincident with the last write of frame 2
    pulse_rst();
    chk("lit_r1_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("lit_r1_overrun", 64'(overrun), 64'd0);
    chk("lit_r1_busy", 64'(busy), 64'd0);
    for (int d = 101; d <= 113; d++) sample(32'(d));
    @(posedge clk); #1; fs = 1'b1; data_in = 32'd114;
    @(posedge clk); #1; sort_done = 1'b1;
    @(posedge clk); #1; sort_done = 1'b0; fs = 1'b0;
    chk("lit_co_start", 64'(sort_start), 64'd1);
    chk("lit_co_bank", 64'(sort_bank), 64'd1);
    chk("lit_co_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("lit_co_overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1;

    // Record enable low mid-frame, then resume at the same address
    for (int d = 201; d <= 203; d++) sample(32'(d));
    en_rec_in = 1'b0;
    n0 = n_wr;
    for (int d = 0; d < 10; d++) sample(32'(300 + d));
    chk("lit_en_nowrite", 64'(n_wr), 64'(n0));
    en_rec_in = 1'b1;
    sample(32'd204);
    chk("lit_en_addr", 64'(last_wr_addr), 64'd3);
    chk("lit_en_data", 64'(last_wr_data), 64'd204);
    sample(32'd205);

    // Reset mid-frame discards the partial frame and emits no start
    n0 = n_start;
    pulse_rst();
    chk("lit_r2_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("lit_r2_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("lit_r2_nostart", 64'(n_start), 64'(n0));
    sample(32'd206);
    chk("lit_r2_addr", 64'(last_wr_addr), 64'd0);
    chk("lit_r2_bank", 64'(last_wr_bank), 64'd0);

    // Randomized traffic: busy sorter first, then a slow one to force overruns
    ph = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (ph == 0) begin
        fs = ~fs;
        ph = int'($urandom_range(4, 2));
      end
      ph--;
      data_in = $urandom();
      if (sort_done) sort_done = 1'b0;
      else sort_done = ($urandom_range((c < 2000) ? 5 : 29, 0) == 0);
      if ($urandom_range(59, 0) == 0) en_rec_in = ~en_rec_in;
      rst = ($urandom_range(599, 0) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; sort_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
